// File: rtl/reg_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_pkg: widths, register map and helpers shared with the   |
// | decoder and the multiply-immediate unit.    Rev 1.0              |
// +------------------------------------------------------------------+
package reg_file_pkg;

  localparam int REG_WIDTH    = 8;
  localparam int ADDR_WIDTH   = 3;
  localparam int REG_SIZE     = 8;
  localparam int SW_REG_ADDR  = 1;
  localparam int LED_REG_ADDR = 2;

  typedef logic [REG_WIDTH-1:0]  reg_word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  // True when the address selects an implemented register slot.
  function automatic logic f_addr_valid(input reg_addr_t a, input int num_regs);
    return (int'(a) < num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_if: read/write/switch/LED bundle of the register file.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface reg_file_if;
  import reg_file_pkg::*;

  reg_addr_t ra_addr;
  reg_word_t ra_data;
  reg_addr_t rb_addr;
  reg_word_t rb_data;
  logic      we;
  reg_addr_t wa_addr;
  reg_word_t wd;
  reg_word_t sw_in;
  reg_word_t led_out;

  modport master (
    output ra_addr, rb_addr, we, wa_addr, wd, sw_in,
    input  ra_data, rb_data, led_out
  );

  modport slave (
    input  ra_addr, rb_addr, we, wa_addr, wd, sw_in,
    output ra_data, rb_data, led_out
  );

endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file: picoMIPS register file, r0 hardwired to zero, switch   |
// | input on SW_REG, LED output from LED_REG.   Rev 1.0              |
// +------------------------------------------------------------------+
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = REG_SIZE,
  parameter int SW_REG   = SW_REG_ADDR,
  parameter int LED_REG  = LED_REG_ADDR
) (
  input  logic      clk,
  input  logic      reset,
  reg_file_if.slave bus
);

  localparam reg_addr_t c_zero_addr = '0;
  localparam reg_addr_t c_sw_addr   = reg_addr_t'(SW_REG);
  localparam reg_addr_t c_led_addr  = reg_addr_t'(LED_REG);

  reg_word_t r_regs [NUM_REGS];
  reg_word_t r_sw_sync1;
  reg_word_t r_sw_sync2;
  reg_word_t r_led;

  logic      w_wr_en;
  reg_word_t w_ra_data;
  reg_word_t w_rb_data;

  assign w_wr_en = bus.we
                && f_addr_valid(bus.wa_addr, NUM_REGS)
                && (bus.wa_addr != c_zero_addr)
                && (bus.wa_addr != c_sw_addr);

  // led_out mirrors the post-edge value of LED_REG, so it loads on the same edge as the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_led <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.wa_addr] <= bus.wd;
      if (bus.wa_addr == c_led_addr) begin
        r_led <= bus.wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= bus.sw_in;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  // Reads come only from stored state: ra_data feeds wd combinationally through the multiplier.
  function automatic reg_word_t f_read(input reg_addr_t a);
    reg_word_t v;
    v = '0;
    if (a == c_sw_addr) begin
      v = r_sw_sync2;
    end else if ((a != c_zero_addr) && f_addr_valid(a, NUM_REGS)) begin
      v = r_regs[a];
    end
    return v;
  endfunction

  always_comb begin
    w_ra_data = f_read(bus.ra_addr);
    w_rb_data = f_read(bus.rb_addr);
  end

  assign bus.ra_data = w_ra_data;
  assign bus.rb_data = w_rb_data;
  assign bus.led_out = r_led;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_file: scoreboard bench for reg_file.  Rev 1.0             |
// +------------------------------------------------------------------+
module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct packed {
    reg_word_t a;
    reg_word_t b;
    reg_word_t led;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  reg_word_t m_regs [8];
  reg_word_t m_s1;
  reg_word_t m_s2;
  reg_word_t m_led;

  reg_file_if rf_if ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  always #5 clk = ~clk;

  // Reference model of the architectural state, advanced on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= '0;
      m_s1  <= '0;
      m_s2  <= '0;
      m_led <= '0;
    end else begin
      if (rf_if.we && rf_if.wa_addr != 3'd0 && rf_if.wa_addr != 3'd1)
        m_regs[rf_if.wa_addr] <= rf_if.wd;
      m_led <= (rf_if.we && rf_if.wa_addr == 3'd2) ? rf_if.wd : m_regs[2];
      m_s1  <= rf_if.sw_in;
      m_s2  <= m_s1;
    end
  end

  function automatic reg_word_t m_read(input reg_addr_t a);
    if (a == 3'd0) return '0;
    if (a == 3'd1) return m_s2;
    return m_regs[a];
  endfunction

  task automatic apply(input logic rst_v, input logic we_v, input reg_addr_t wa,
                       input reg_word_t wdat, input reg_addr_t ra, input reg_addr_t rb,
                       input reg_word_t sw, input exp_t e);
    reset         = rst_v;
    rf_if.we      = we_v;
    rf_if.wa_addr = wa;
    rf_if.wd      = wdat;
    rf_if.ra_addr = ra;
    rf_if.rb_addr = rb;
    rf_if.sw_in   = sw;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t got;
    apply(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, '0);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 3'd0, 8'h00, reg_addr_t'(i), reg_addr_t'(7 - i), 8'h00, '0);
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL reset_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL reset_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL reset_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_bypass();
    exp_t got;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0:       apply(1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 8'h00, '{8'h00, 8'h00, 8'h00});
        default: apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h00, '{8'hA5, 8'hA5, 8'h00});
      endcase
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL bypass_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL bypass_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL bypass_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_protected_writes();
    exp_t got;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd1, 8'h00, '{8'h00, 8'h00, 8'h00});
        1:       apply(1'b0, 1'b1, 3'd1, 8'h55, 3'd0, 3'd1, 8'h00, '{8'h00, 8'h00, 8'h00});
        default: apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0, 8'h00, '{8'h00, 8'h00, 8'h00});
      endcase
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL protect_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL protect_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL protect_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_sync();
    exp_t got;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 8'h3C, '{8'h00, 8'h00, 8'h00});
        1:       apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 8'h3C, '{8'h00, 8'h00, 8'h00});
        default: apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 8'h3C, '{8'h3C, 8'h3C, 8'h00});
      endcase
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL sw_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL sw_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL sw_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_led();
    exp_t got;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(1'b0, 1'b1, 3'd2, 8'h80, 3'd2, 3'd1, 8'h3C, '{8'h00, 8'h3C, 8'h00});
        1:       apply(1'b0, 1'b1, 3'd4, 8'h11, 3'd2, 3'd4, 8'h3C, '{8'h80, 8'h00, 8'h80});
        default: apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h3C, '{8'h11, 8'h80, 8'h80});
      endcase
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL led_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL led_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL led_out row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_priority();
    exp_t got;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       apply(1'b1, 1'b1, 3'd5, 8'h7E, 3'd5, 3'd3, 8'h3C, '{8'h00, 8'hA5, 8'h80});
        1:       apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h3C, '{8'h00, 8'h00, 8'h00});
        default: apply(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 8'h3C, '{8'h00, 8'h00, 8'h00});
      endcase
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL rstprio_ra row=%0d got=%h exp=%h", i, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL rstprio_rb row=%0d got=%h exp=%h", i, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL rstprio_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    exp_t      got;
    reg_addr_t ra;
    reg_addr_t rb;
    for (int i = 0; i < 200; i++) begin
      ra = reg_addr_t'($urandom_range(0, 7));
      rb = reg_addr_t'($urandom_range(0, 7));
      apply(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            reg_addr_t'($urandom_range(0, 7)), reg_word_t'($urandom_range(0, 255)),
            ra, rb, reg_word_t'($urandom_range(0, 255)),
            '{m_read(ra), m_read(rb), m_led});
      @(negedge clk);
      got = exp_q.pop_front();
      checks += 3;
      if (rf_if.ra_data !== got.a) begin failures++; $display("FAIL rand_ra row=%0d addr=%0d got=%h exp=%h", i, ra, rf_if.ra_data, got.a); end
      if (rf_if.rb_data !== got.b) begin failures++; $display("FAIL rand_rb row=%0d addr=%0d got=%h exp=%h", i, rb, rf_if.rb_data, got.b); end
      if (rf_if.led_out !== got.led) begin failures++; $display("FAIL rand_led row=%0d got=%h exp=%h", i, rf_if.led_out, got.led); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    rf_if.we      = 1'b0;
    rf_if.wa_addr = '0;
    rf_if.wd      = '0;
    rf_if.ra_addr = '0;
    rf_if.rb_addr = '0;
    rf_if.sw_in   = '0;
    test_reset();
    test_no_bypass();
    test_protected_writes();
    test_sw_sync();
    test_led();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
